// File: rtl/style_color_pkg.sv
// Shared definitions for the style colour read path: FSM states, colour
// property identifiers, ARGB field bounds and the read-address layout.
package style_color_pkg;

  // Default widths of the property selector and the ARGB colour word.
  localparam int unsigned PROP_W_DEF  = 4;
  localparam int unsigned COLOR_W_DEF = 32;

  // ARGB layout: A[31:24] R[23:16] G[15:8] B[7:0].
  localparam int unsigned ALPHA_HI = 31;
  localparam int unsigned ALPHA_LO = 24;

  // The style read address is {visited_bit, prop}; this is the position of
  // the visited selector for the default property width.
  localparam int unsigned VISITED_BIT = PROP_W_DEF;

  // Read-side sequencing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_U  = 3'd1,
    CAP_U = 3'd2,
    CAP_V = 3'd3,
    RESP  = 3'd4
  } state_t;

  // Colour-property identifiers presented on req_prop.
  typedef enum logic [PROP_W_DEF-1:0] {
    PROP_COLOR           = 4'd0,
    PROP_BACKGROUND      = 4'd1,
    PROP_BORDER_TOP      = 4'd2,
    PROP_BORDER_RIGHT    = 4'd3,
    PROP_BORDER_BOTTOM   = 4'd4,
    PROP_BORDER_LEFT     = 4'd5,
    PROP_OUTLINE         = 4'd6,
    PROP_TEXT_DECORATION = 4'd7,
    PROP_COLUMN_RULE     = 4'd8,
    PROP_TEXT_EMPHASIS   = 4'd9,
    PROP_TEXT_STROKE     = 4'd10,
    PROP_TEXT_FILL       = 4'd11
  } color_prop_t;

endpackage

// File: rtl/visited_color_blend.sv
// Combines the unvisited and visited colours: a transparent visited colour
// leaves the unvisited colour untouched, otherwise the visited RGB is used
// with the unvisited alpha.
module visited_color_blend
  import style_color_pkg::*;
#(
  parameter int unsigned COLOR_W = 32
) (
  input  logic [COLOR_W-1:0] unv,
  input  logic [COLOR_W-1:0] vis,
  output logic [COLOR_W-1:0] merged
);

  logic vis_transparent;

  // Transparent check and alpha splice.
  always_comb begin
    vis_transparent = (vis[ALPHA_HI:ALPHA_LO] == '0);
    if (vis_transparent) begin
      merged = unv;
    end else begin
      merged = {unv[ALPHA_HI:ALPHA_LO], vis[ALPHA_LO-1:0]};
    end
  end

endmodule

// File: rtl/style_color_reader.sv
// Resolves the visited-dependent colour of one colour property: reads the
// unvisited colour (and the visited colour for elements inside a visited
// link), applies the currentcolor fallbacks and returns one ARGB value over
// a valid/ready response channel.
module style_color_reader
  import style_color_pkg::*;
#(
  parameter int unsigned PROP_W  = 4,
  parameter int unsigned COLOR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [PROP_W-1:0]  req_prop,
  input  logic               req_inside_visited_link,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [COLOR_W-1:0] rsp_color,
  output logic               style_rd_en,
  output logic [PROP_W:0]    style_rd_addr,
  input  logic [COLOR_W:0]   style_rd_data,
  input  logic [COLOR_W-1:0] cur_color,
  input  logic [COLOR_W-1:0] cur_visited_color
);

  state_t             state;
  state_t             state_nxt;

  logic [PROP_W-1:0]  prop_q;
  logic               visited_q;
  logic [COLOR_W-1:0] unv_q;
  logic [COLOR_W-1:0] rsp_color_q;

  logic               accept;
  logic               cap_unv;
  logic               rsp_load;
  logic [COLOR_W-1:0] rsp_nxt;

  logic               rd_data_valid;
  logic [COLOR_W-1:0] rd_data_color;
  logic [COLOR_W-1:0] unv_sel;
  logic [COLOR_W-1:0] vis_sel;
  logic [COLOR_W-1:0] blend_out;

  // Split the read word and apply the currentcolor fallbacks; the inherited
  // colours only matter in the cycle the matching read data is captured.
  always_comb begin
    rd_data_valid = style_rd_data[COLOR_W];
    rd_data_color = style_rd_data[COLOR_W-1:0];
    unv_sel       = rd_data_valid ? rd_data_color : cur_color;
    vis_sel       = rd_data_valid ? rd_data_color : cur_visited_color;
  end

  // The visited read lands one cycle after the unvisited one, so the
  // unvisited colour is blended from its register.
  visited_color_blend #(
    .COLOR_W (COLOR_W)
  ) u_blend (
    .unv    (unv_q),
    .vis    (vis_sel),
    .merged (blend_out)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, handshake and read-port control.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    style_rd_en   = 1'b0;
    style_rd_addr = '0;
    accept        = 1'b0;
    cap_unv       = 1'b0;
    rsp_load      = 1'b0;
    rsp_nxt       = rsp_color_q;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = RD_U;
        end
      end

      RD_U: begin
        style_rd_en   = 1'b1;
        style_rd_addr = {1'b0, prop_q};
        state_nxt     = CAP_U;
      end

      CAP_U: begin
        cap_unv = 1'b1;
        if (visited_q) begin
          // Issue the visited read while capturing the unvisited data.
          style_rd_en   = 1'b1;
          style_rd_addr = {1'b1, prop_q};
          state_nxt     = CAP_V;
        end else begin
          rsp_load  = 1'b1;
          rsp_nxt   = unv_sel;
          state_nxt = RESP;
        end
      end

      CAP_V: begin
        rsp_load  = 1'b1;
        rsp_nxt   = blend_out;
        state_nxt = RESP;
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, unvisited capture and response colour register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prop_q      <= '0;
      visited_q   <= 1'b0;
      unv_q       <= '0;
      rsp_color_q <= '0;
    end else begin
      if (accept) begin
        prop_q    <= req_prop;
        visited_q <= req_inside_visited_link;
      end
      if (cap_unv) begin
        unv_q <= unv_sel;
      end
      if (rsp_load) begin
        rsp_color_q <= rsp_nxt;
      end
    end
  end

  assign rsp_color = rsp_color_q;

endmodule

// File: tb/tb_style_color_reader.sv
// Directed bench for style_color_reader: a table of requests with
// hand-computed colours, plus back-pressure and mid-operation reset sequences.
module tb_style_color_reader;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_prop;
  logic        req_inside_visited_link;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_color;
  logic        style_rd_en;
  logic [4:0]  style_rd_addr;
  logic [32:0] style_rd_data;
  logic [31:0] cur_color;
  logic [31:0] cur_visited_color;

  int n_cmp;
  int n_fail;

  // Style register model and read log.
  logic        mem_v [0:31];
  logic [31:0] mem_d [0:31];
  int          rd_cnt;
  logic [4:0]  rd_log [0:7];

  style_color_reader #(
    .PROP_W  (4),
    .COLOR_W (32)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_prop                (req_prop),
    .req_inside_visited_link (req_inside_visited_link),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_color               (rsp_color),
    .style_rd_en             (style_rd_en),
    .style_rd_addr           (style_rd_addr),
    .style_rd_data           (style_rd_data),
    .cur_color               (cur_color),
    .cur_visited_color       (cur_visited_color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  prop;
    logic        vis;
    logic        uv;
    logic [31:0] ud;
    logic        vv;
    logic [31:0] vd;
    logic [31:0] cc;
    logic [31:0] cvc;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [0:7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-cycle-latency read port: address sampled in the read cycle, data
  // presented for the following cycle; idle cycles return invalid junk.
  initial begin
    logic       en;
    logic [4:0] a;
    style_rd_data = '0;
    forever begin
      @(negedge clk);
      en = style_rd_en;
      a  = style_rd_addr;
      if (en) begin
        if (rd_cnt < 8) rd_log[rd_cnt] = a;
        rd_cnt++;
      end
      @(posedge clk);
      #1;
      style_rd_data = en ? {mem_v[a], mem_d[a]} : {1'b0, 32'hDEADBEEF};
    end
  end

  task automatic load_vec(input vec_t v);
    mem_v[{1'b0, v.prop}] = v.uv;
    mem_d[{1'b0, v.prop}] = v.ud;
    mem_v[{1'b1, v.prop}] = v.vv;
    mem_d[{1'b1, v.prop}] = v.vd;
    cur_color         = v.cc;
    cur_visited_color = v.cvc;
  endtask

  // Issue a request at a negedge, return the number of edges from the
  // accept edge to the first edge at which rsp_valid is seen high (0 = never).
  task automatic issue(input vec_t v, output int lat);
    @(negedge clk);
    chk({v.name, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    rd_cnt                  = 0;
    req_valid               = 1'b1;
    req_prop                = v.prop;
    req_inside_visited_link = v.vis;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = j;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    load_vec(v);
    issue(v, lat);
    chk({v.name, "_latency"}, 64'(lat), v.vis ? 64'd4 : 64'd3);
    chk({v.name, "_color"}, {32'd0, rsp_color}, {32'd0, v.exp});
    chk({v.name, "_reads"}, 64'(rd_cnt), v.vis ? 64'd2 : 64'd1);
    chk({v.name, "_addr_u"}, {59'd0, rd_log[0]}, {59'd0, 1'b0, v.prop});
    if (v.vis) chk({v.name, "_addr_v"}, {59'd0, rd_log[1]}, {59'd0, 1'b1, v.prop});
    chk({v.name, "_busy_ready"}, {63'd0, req_ready}, 64'd0);
    chk({v.name, "_resp_rd_en"}, {63'd0, style_rd_en}, 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({v.name, "_drop_valid"}, {63'd0, rsp_valid}, 64'd0);
    chk({v.name, "_idle_ready"}, {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    int         lat;
    logic [31:0] held;
    vec_t       bp;

    n_cmp = 0;
    n_fail = 0;
    rd_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      mem_v[i] = 1'b0;
      mem_d[i] = 32'h0;
    end
    for (int i = 0; i < 8; i++) rd_log[i] = 5'h1F;

    vecs[0] = '{"unv_valid",    4'd0,  1'b0, 1'b1, 32'hFF112233, 1'b0, 32'h0,        32'h0,        32'h0,        32'hFF112233};
    vecs[1] = '{"unv_fallback", 4'd1,  1'b0, 1'b0, 32'h11111111, 1'b0, 32'h0,        32'h80ABCDEF, 32'h0,        32'h80ABCDEF};
    vecs[2] = '{"vis_merge",    4'd3,  1'b1, 1'b1, 32'h40102030, 1'b1, 32'hFFAABBCC, 32'h0,        32'h0,        32'h40AABBCC};
    vecs[3] = '{"vis_transp",   4'd5,  1'b1, 1'b1, 32'hFF010203, 1'b1, 32'h00AABBCC, 32'h0,        32'h0,        32'hFF010203};
    vecs[4] = '{"vis_fallback", 4'd6,  1'b1, 1'b1, 32'hFF998877, 1'b0, 32'h12345678, 32'h0,        32'hFF445566, 32'hFF445566};
    vecs[5] = '{"both_fb_mix",  4'd15, 1'b1, 1'b0, 32'h0,        1'b1, 32'h9ACBDEF0, 32'h12345678, 32'h0,        32'h12CBDEF0};
    vecs[6] = '{"unv_zero",     4'd9,  1'b0, 1'b1, 32'h00000000, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h00000000};
    vecs[7] = '{"both_fb_tr",   4'd2,  1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h00FF00FF, 32'h00112233, 32'h00FF00FF};

    reset                   = 1'b1;
    req_valid               = 1'b0;
    req_prop                = '0;
    req_inside_visited_link = 1'b0;
    rsp_ready               = 1'b0;
    cur_color               = '0;
    cur_visited_color       = '0;

    @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_color", {32'd0, rsp_color}, 64'd0);
    chk("rst_rd_en",     {63'd0, style_rd_en}, 64'd0);
    chk("rst_rd_addr",   {59'd0, style_rd_addr}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-pressure: response held, colour stable, new requests and inherited
    // colour changes ignored while busy.
    bp = vecs[2];
    bp.name = "bp";
    load_vec(bp);
    issue(bp, lat);
    chk("bp_latency", 64'(lat), 64'd4);
    held = rsp_color;
    chk("bp_color", {32'd0, held}, 64'h40AABBCC);
    req_valid = 1'b1;
    req_prop  = 4'd7;
    cur_color = 32'hCAFEF00D;
    cur_visited_color = 32'hBADDCAFE;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid_held", {63'd0, rsp_valid}, 64'd1);
      chk("bp_color_stable", {32'd0, rsp_color}, 64'h40AABBCC);
      chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_drop_valid", {63'd0, rsp_valid}, 64'd0);
    chk("bp_idle_ready", {63'd0, req_ready}, 64'd1);
    chk("bp_no_extra_reads", 64'(rd_cnt), 64'd2);

    // Reset while the visited read is being captured.
    load_vec(vecs[3]);
    @(negedge clk);
    req_valid               = 1'b1;
    req_prop                = vecs[3].prop;
    req_inside_visited_link = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_in_capv_rd_en", {63'd0, style_rd_en}, 64'd0);
    chk("rstmid_in_capv_ready", {63'd0, req_ready}, 64'd0);
    reset = 1'b1;
    #1;
    chk("rstmid_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rstmid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rstmid_rsp_color", {32'd0, rsp_color}, 64'd0);
    chk("rstmid_rd_en",     {63'd0, style_rd_en}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (rsp_valid) lat = k;
    end
    chk("rstmid_no_resp", 64'(lat), 64'd0);
    chk("rstmid_idle_ready", {63'd0, req_ready}, 64'd1);

    vecs[0].name = "post_rst";
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
